// File: rtl/pearson_hash_checker.sv
// Pearson hash checker: strips the trailing hash byte from each frame,
// forwards the payload, and reports match/length per frame.
// Ports: clk, reset (async active-low); s_* byte stream in (tlast marks
// the hash byte); m_* payload stream out (tlast on last payload byte);
// res_valid/res_ok/res_len/res_ready frame result handshake;
// stat_good/stat_bad frame counters, built only when the macro
// PEARSON_CHK_STATS_EN is defined (tied to 0 otherwise).
module pearson_hash_checker #(
   parameter logic [7:0] INIT  = 8'h00,
   parameter int         LEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       s_tdata,
   input  logic             s_tvalid,
   input  logic             s_tlast,
   output logic             s_tready,
   output logic [7:0]       m_tdata,
   output logic             m_tvalid,
   output logic             m_tlast,
   input  logic             m_tready,
   output logic             res_valid,
   output logic             res_ok,
   output logic [LEN_W-1:0] res_len,
   input  logic             res_ready,
   output logic [31:0]      stat_good,
   output logic [31:0]      stat_bad
);

   typedef enum logic {ACC, RESULT} state_t;

   state_t           state;
   state_t           state_nx;
   logic             h_vld;
   logic [7:0]       h_dat;
   logic             o_vld;
   logic [7:0]       o_dat;
   logic             o_lst;
   logic [7:0]       hash;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_inc;
   logic             r_ok;
   logic [LEN_W-1:0] r_len;
   logic             acc;
   logic             res_hs;
   logic [7:0]       hf;

   function automatic logic [7:0] perm(input logic [7:0] i);
      return i * 8'd167 + 8'd13;
   endfunction

   assign acc     = s_tvalid && s_tready;
   assign res_hs  = res_valid && res_ready;
   assign hf      = h_vld ? perm(hash ^ h_dat) : hash;
   assign len_inc = (&len) ? len : len + {{(LEN_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ACC;
      else        state <= state_nx;
   end

   // s_tready is held low while reset is asserted
   always_comb begin
      state_nx  = state;
      s_tready  = 1'b0;
      res_valid = 1'b0;
      unique case (state)
         ACC: begin
            s_tready = reset && (!o_vld || m_tready);
            if (s_tvalid && s_tready && s_tlast) state_nx = RESULT;
         end
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = ACC;
         end
         default: state_nx = ACC;
      endcase
   end

   // H lags one byte so the last payload byte can be tagged when
   // the hash beat arrives
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_vld <= 1'b0;
         h_dat <= 8'h00;
         o_vld <= 1'b0;
         o_dat <= 8'h00;
         o_lst <= 1'b0;
         hash  <= INIT;
         len   <= '0;
         r_ok  <= 1'b0;
         r_len <= '0;
      end else begin
         if (o_vld && m_tready) o_vld <= 1'b0;
         if (acc) begin
            if (h_vld) begin
               o_vld <= 1'b1;
               o_dat <= h_dat;
               o_lst <= s_tlast;
            end
            if (s_tlast) begin
               h_vld <= 1'b0;
               r_ok  <= (s_tdata == hf);
               r_len <= h_vld ? len_inc : len;
            end else begin
               h_vld <= 1'b1;
               h_dat <= s_tdata;
               if (h_vld) begin
                  hash <= perm(hash ^ h_dat);
                  len  <= len_inc;
               end
            end
         end
         if (res_hs) begin
            hash <= INIT;
            len  <= '0;
         end
      end
   end

   assign m_tvalid = o_vld;
   assign m_tdata  = o_dat;
   assign m_tlast  = o_vld && o_lst;
   assign res_ok   = r_ok;
   assign res_len  = r_len;

`ifdef PEARSON_CHK_STATS_EN
   logic [31:0] n_good;
   logic [31:0] n_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_good <= '0;
         n_bad  <= '0;
      end else if (res_hs) begin
         if (r_ok) n_good <= n_good + 32'd1;
         else      n_bad  <= n_bad + 32'd1;
      end
   end

   assign stat_good = n_good;
   assign stat_bad  = n_bad;
`else
   assign stat_good = 32'd0;
   assign stat_bad  = 32'd0;
`endif

endmodule
